// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch queue.
//   WORD_BYTES      : bytes per instruction word
//   ALIGN_BITS      : low address bits cleared to word-align a fetch address
//   ADDR_ALIGN_MASK : 32-bit mask that word-aligns an address
//   NOP_INSTR       : instruction word presented when the queue is empty
package fetch_pkg;

    localparam int unsigned WORD_BYTES      = 4;
    localparam int unsigned ALIGN_BITS      = $clog2(WORD_BYTES);
    localparam logic [31:0] ADDR_ALIGN_MASK = ~(32'(WORD_BYTES) - 32'd1);
    localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO used for both the in-flight PC list and the decoded
// instruction queue.
//   clk, reset : clock, asynchronous active-high reset
//   push       : write push_data at the tail
//   push_data  : WIDTH-bit entry
//   pop        : drop the head entry
//   clear      : empty the FIFO next cycle (wins over push/pop)
//   head       : entry at the head (meaningful only when count != 0)
//   count      : number of stored entries, 0..DEPTH
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

    no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && !clear && (count == ($clog2(DEPTH)+1)'(DEPTH))));
    no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(pop && !clear && (count == '0)));

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: accepts fetch addresses from the PC block, issues
// word reads to instruction memory, pairs in-order responses with their PC and
// buffers {pc, instruction} for decode. A flush discards queued entries and
// marks every in-flight read as stale so its response is thrown away.
//   clk, reset     : clock, asynchronous active-high reset
//   pc_in/pc_valid : fetch address offered by the PC block
//   pc_ready       : fetch accepted this cycle
//   flush          : redirect; empties the queue and drops in-flight reads
//   mem_req_*      : read request to instruction memory (word-aligned address)
//   mem_rsp_*      : in-order read data, always accepted
//   inst_*         : head of the instruction queue with valid/ready handshake
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic              flush,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
);

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

    logic [CNT_W-1:0]   outstanding_q;
    logic [CNT_W-1:0]   outstanding_d;
    logic [CNT_W-1:0]   drop_cnt_q;
    logic [CNT_W-1:0]   drop_cnt_d;
    logic [CNT_W-1:0]   occupancy_q;
    logic [CNT_W-1:0]   pc_count;
    logic [CNT_W-1:0]   credit;
    logic [ADDR_W-1:0]  aligned_pc;
    logic [ADDR_W-1:0]  pc_head;
    logic [ENTRY_W-1:0] q_head;
    logic               req_fire;
    logic               rsp_seen;
    logic               rsp_deliver;
    logic               inst_pop;

    // ------------------------------------------------------------------
    // Request side: credit counts from registered state only, so a slot
    // freed by decode this cycle becomes usable next cycle.
    // ------------------------------------------------------------------
    assign aligned_pc    = {pc_in[ADDR_W-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
    assign credit        = CNT_W'(DEPTH) - occupancy_q - outstanding_q;
    assign mem_req_valid = pc_valid & (credit != '0) & ~flush;
    assign mem_req_addr  = aligned_pc;
    assign pc_ready      = mem_req_valid & mem_req_ready;
    assign req_fire      = pc_ready;

    // ------------------------------------------------------------------
    // Response side: the first drop_cnt responses belong to fetches issued
    // before the last flush and are discarded without touching the PC list.
    // ------------------------------------------------------------------
    assign rsp_seen    = mem_rsp_valid & (outstanding_q != '0);
    assign rsp_deliver = rsp_seen & ~flush & (drop_cnt_q == '0) & (pc_count != '0);

    assign inst_valid = (occupancy_q != '0);
    assign inst_pop   = inst_valid & inst_ready & ~flush;
    assign inst_pc    = inst_valid ? q_head[ENTRY_W-1:DATA_W] : '0;
    assign inst_data  = inst_valid ? q_head[DATA_W-1:0] : DATA_W'(NOP_INSTR);

    always_comb begin
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        if (flush) begin
            // Every read still in flight after this cycle is stale; this
            // cycle's response (if any) is already discarded by the flush.
            outstanding_d = outstanding_q - CNT_W'(rsp_seen);
            drop_cnt_d    = outstanding_q - CNT_W'(rsp_seen);
        end else begin
            outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_seen);
            if (rsp_seen && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_pc_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (req_fire),
        .push_data (aligned_pc),
        .pop       (rsp_deliver),
        .clear     (flush),
        .head      (pc_head),
        .count     (pc_count)
    );

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_inst_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (rsp_deliver),
        .push_data ({pc_head, mem_rsp_data}),
        .pop       (inst_pop),
        .clear     (flush),
        .head      (q_head),
        .count     (occupancy_q)
    );

    credit_bound: assert property (@(posedge clk) disable iff (reset)
        ({1'b0, occupancy_q} + {1'b0, outstanding_q}) <= (CNT_W+1)'(DEPTH));
    drop_bound: assert property (@(posedge clk) disable iff (reset)
        drop_cnt_q <= outstanding_q);

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } sb_t;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mreq_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_in = '0;
    logic        pc_valid = 1'b0;
    logic        pc_ready;
    logic        flush = 1'b0;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready = 1'b1;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;

    int unsigned checks = 0;
    int unsigned passes = 0;
    int unsigned cyc = 0;
    int unsigned lat = 1;
    int unsigned n_deliv = 0;
    logic [31:0] last_pc = '0;
    sb_t         sb[$];
    mreq_t       memq[$];
    int unsigned deliv_cyc[$];

    instr_fetch_queue #(
        .ADDR_W (32),
        .DATA_W (32),
        .DEPTH  (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_in         (pc_in),
        .pc_valid      (pc_valid),
        .pc_ready      (pc_ready),
        .flush         (flush),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .inst_valid    (inst_valid),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mk_data(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    // Instruction memory: in-order, fixed latency of lat cycles.
    always begin
        @(negedge clk);
        if (!reset && mem_req_valid && mem_req_ready)
            memq.push_back('{addr: mem_req_addr, due: cyc + lat});
        @(posedge clk);
        #1;
        if (reset) begin
            memq.delete();
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end else if (memq.size() != 0 && memq[0].due <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mk_data(memq[0].addr);
            void'(memq.pop_front());
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_pc(input logic [31:0] a);
        bit acc = 1'b0;
        int unsigned n = 0;
        pc_in    = a;
        pc_valid = 1'b1;
        while (!acc && n < 50) begin
            #1;
            acc = pc_ready;
            tick();
            n++;
        end
        chk("send_accept", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (n < 60 && (sb.size() != 0 || inst_valid)) begin
            tick();
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int unsigned base;
        int unsigned acc_cnt;
        int unsigned idx;
        int unsigned n;
        int unsigned exp_drop;
        bit          found;
        bit          acc;
        logic [31:0] a;

        // Scoreboard monitor: expected entries enter on accepted fetches and
        // leave on decode handshakes; flush and reset discard them.
        fork
            forever begin
                sb_t e;
                @(negedge clk);
                if (reset || flush) begin
                    sb.delete();
                end else begin
                    if (inst_valid && inst_ready) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_inst", {32'd0, inst_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
                        end else begin
                            e = sb.pop_front();
                            chk("inst_pc", 64'(inst_pc), 64'(e.pc));
                            chk("inst_data", 64'(inst_data), 64'(e.data));
                            n_deliv++;
                            last_pc = inst_pc;
                            deliv_cyc.push_back(cyc);
                        end
                    end
                    if (pc_ready) begin
                        sb.push_back('{pc: pc_in & 32'hFFFF_FFFC,
                                       data: mk_data(pc_in & 32'hFFFF_FFFC)});
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) tick();
        #1;
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst_data", 64'(inst_data), 64'd0);
        chk("rst_inst_pc", 64'(inst_pc), 64'd0);
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        reset = 1'b0;
        tick();

        // 1: 1-cycle memory, streaming, one instruction per cycle
        lat = 1;
        inst_ready = 1'b1;
        base = n_deliv;
        send_pc(32'h0);
        send_pc(32'h4);
        send_pc(32'h8);
        send_pc(32'hC);
        pc_valid = 1'b0;
        drain();
        chk("t1_count", 64'(n_deliv - base), 64'd4);
        for (int i = 1; i < 4; i++)
            chk("t1_back_to_back", 64'(deliv_cyc[base + i] - deliv_cyc[base + i - 1]), 64'd1);

        // 5: unaligned PC
        pc_in = 32'h0000_0006;
        pc_valid = 1'b1;
        #1;
        chk("t5_req_addr", 64'(mem_req_addr), 64'h4);
        send_pc(32'h0000_0006);
        pc_valid = 1'b0;
        drain();
        chk("t5_inst_pc", 64'(last_pc), 64'h4);

        // 2: decode stalled, credit limits acceptance to DEPTH
        inst_ready = 1'b0;
        acc_cnt = 0;
        idx = 0;
        pc_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            pc_in = 32'h40 + 4 * idx;
            #1;
            if (pc_ready) begin
                acc_cnt++;
                idx++;
            end
            tick();
        end
        pc_in = 32'h40 + 4 * idx;
        #1;
        chk("t2_accepted", 64'(acc_cnt), 64'd4);
        chk("t2_pc_ready_full", 64'(pc_ready), 64'd0);
        chk("t2_head_valid", 64'(inst_valid), 64'd1);
        chk("t2_head_stable", 64'(inst_pc), 64'h40);
        inst_ready = 1'b1;
        base = n_deliv;
        n = 0;
        while (idx < 8 && n < 60) begin
            pc_in = 32'h40 + 4 * idx;
            #1;
            if (pc_ready) idx++;
            tick();
            n++;
        end
        pc_valid = 1'b0;
        drain();
        chk("t2_total", 64'(n_deliv - base), 64'd8);
        chk("t2_last_pc", 64'(last_pc), 64'h5C);

        // 3: 3 outstanding with 4-cycle memory, flush, refetch at 0x100
        lat = 4;
        send_pc(32'h10);
        send_pc(32'h14);
        send_pc(32'h18);
        pc_in = 32'h100;
        flush = 1'b1;
        #1;
        chk("t3_no_req_on_flush", 64'(mem_req_valid), 64'd0);
        chk("t3_no_ready_on_flush", 64'(pc_ready), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("t3_drop_cnt", 64'(dut.drop_cnt_q), 64'd3);
        base = n_deliv;
        send_pc(32'h100);
        pc_valid = 1'b0;
        n = 0;
        while (n_deliv == base && n < 60) begin
            tick();
            n++;
        end
        chk("t3_first_after_flush", 64'(last_pc), 64'h100);
        drain();

        // 4: flush coincides with a response and a decode handshake
        lat = 2;
        inst_ready = 1'b1;
        a = 32'h300;
        pc_in = a;
        pc_valid = 1'b1;
        found = 1'b0;
        n = 0;
        while (!found && n < 40) begin
            #1;
            if (mem_rsp_valid && inst_valid) begin
                found = 1'b1;
            end else begin
                acc = pc_ready;
                tick();
                if (acc) a = a + 4;
                pc_in = a;
                n++;
            end
        end
        chk("t4_found", 64'(found), 64'd1);
        flush = 1'b1;
        pc_valid = 1'b0;
        exp_drop = memq.size();
        tick();
        flush = 1'b0;
        #1;
        chk("t4_inst_valid_low", 64'(inst_valid), 64'd0);
        chk("t4_drop_cnt", 64'(dut.drop_cnt_q), 64'(exp_drop));
        send_pc(32'h400);
        pc_valid = 1'b0;
        drain();
        chk("t4_refetch", 64'(last_pc), 64'h400);

        // 6: reset with the queue full, then restart from PC 0
        lat = 1;
        inst_ready = 1'b0;
        send_pc(32'h20);
        send_pc(32'h24);
        send_pc(32'h28);
        send_pc(32'h2C);
        pc_in = 32'h30;
        tick();
        tick();
        #1;
        chk("t6_full_valid", 64'(inst_valid), 64'd1);
        chk("t6_full_no_credit", 64'(pc_ready), 64'd0);
        pc_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("t6_rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("t6_rst_inst_data", 64'(inst_data), 64'd0);
        chk("t6_rst_inst_pc", 64'(inst_pc), 64'd0);
        chk("t6_rst_req", 64'(mem_req_valid), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        inst_ready = 1'b1;
        base = n_deliv;
        send_pc(32'h0);
        send_pc(32'h4);
        pc_valid = 1'b0;
        drain();
        chk("t6_restart_count", 64'(n_deliv - base), 64'd2);
        chk("t6_restart_last", 64'(last_pc), 64'h4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
